// File: rtl/note_keypad.sv
// Piano keypad front end: synchronises and debounces eight note buttons, then
// picks the winning key (last pressed, highest index on ties) as a 3-bit note code.
module note_keypad #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [7:0] keys,
    output logic [2:0] scaler,
    output logic       note_on,
    output logic       note_chg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

    logic [7:0]       s1_r;
    logic [7:0]       s2_r;
    logic [7:0]       cand_r;
    logic [7:0]       db_r;
    logic [7:0]       db_prev_r;
    logic [CNT_W-1:0] cnt_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [2:0]       scaler_nxt_s;
    logic             note_on_nxt_s;
    logic             note_chg_nxt_s;
    logic [7:0]       rises_s;

    function automatic logic [2:0] top_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 8'h00;
            s2_r <= 8'h00;
        end else begin
            s1_r <= keys;
            s2_r <= s1_r;
        end
    end

    // Whole-vector debounce: any change in the synchronised vector restarts the count.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cand_r    <= 8'h00;
            db_r      <= 8'h00;
            db_prev_r <= 8'h00;
            cnt_r     <= '0;
        end else begin
            db_prev_r <= db_r;
            if (s2_r != cand_r) begin
                cand_r <= s2_r;
                cnt_r  <= '0;
            end else if (cand_r != db_r) begin
                if (cnt_r == CNT_LAST) begin
                    db_r  <= cand_r;
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign rises_s = db_r & ~db_prev_r;

    // Note selection: a fresh press wins; on release of the current key fall back to the highest held key.
    always_comb begin
        state_nxt_s    = state_r;
        scaler_nxt_s   = scaler;
        note_on_nxt_s  = note_on;
        note_chg_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                note_on_nxt_s = 1'b0;
                if (db_r != 8'h00) begin
                    state_nxt_s    = PLAYING;
                    scaler_nxt_s   = top_index(db_r);
                    note_on_nxt_s  = 1'b1;
                    note_chg_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PLAYING: begin
                note_on_nxt_s = 1'b1;
                if (rises_s != 8'h00) begin
                    scaler_nxt_s = top_index(rises_s);
                end else if ((db_r[scaler] == 1'b0) && (db_r != 8'h00)) begin
                    scaler_nxt_s = top_index(db_r);
                end else if (db_r == 8'h00) begin
                    state_nxt_s   = IDLE;
                    note_on_nxt_s = 1'b0;
                end else begin
                    scaler_nxt_s = scaler;
                end
                note_chg_nxt_s = (scaler_nxt_s != scaler);
            end
            default: begin
                state_nxt_s   = IDLE;
                note_on_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            scaler   <= 3'd0;
            note_on  <= 1'b0;
            note_chg <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            scaler   <= scaler_nxt_s;
            note_on  <= note_on_nxt_s;
            note_chg <= note_chg_nxt_s;
        end
    end

endmodule
